clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
Run-time controller for the board's divided-clock generator. It holds the divide ratio and accepts new ratios over a valid/ready handshake. New ratios are applied only at full-period boundaries, so the output never has runt pulses. It also supports run/stop and N-period burst mode, and sits between the control logic (switch/UART register bank) and the LED/timing logic that consumes clk_out and tick.

Parameters:
CNT_W, 32, width of the half-period counter and divide value
DEFAULT_DIV, 25000000, divide value loaded at reset; half-period = DIV+1 clk cycles
BURST_W, 16, width of the burst period count

Ports:
clk  in  1  system clock, all logic on posedge
rst  in  1  synchronous reset, active-high
en  in  1  level; 1 = run divider, 0 = stop at next period boundary
cfg_valid  in  1  new configuration offered
cfg_ready  out  1  configuration can be accepted this cycle
cfg_div  in  CNT_W  new divide value (0 legal: clk_out = clk/2)
cfg_burst  in  BURST_W  number of full clk_out periods to emit; 0 = continuous
clk_out  out  1  divided clock (registered level)
tick  out  1  one-cycle pulse on every clk_out toggle
done  out  1  one-cycle pulse when a burst completes
busy  out  1  high in RUN or STOP
active_div  out  CNT_W  divide value currently in use

Behaviour:
- Clocking and reset: single clock; reset is synchronous and active-high.
- Reset values: clk_out=0, tick=0, done=0, busy=0, count=0, active_div=DEFAULT_DIV, burst=0, pending=0, state=IDLE, cfg_ready=1.
- Handshake: a transfer occurs on a cycle where cfg_valid && cfg_ready. cfg_div and cfg_burst are sampled in that cycle. cfg_valid may stay high; only one transfer occurs per ready cycle.
- cfg_ready: 1 in IDLE; 1 in RUN/STOP only while pending=0.
- Counter: count increments each cycle in RUN/STOP. The terminal event is count==active_div. On terminal: count<=0, clk_out toggles, tick=1 in the following cycle (registered with clk_out). A period boundary is a terminal where clk_out goes 1->0.
- FSM states IDLE, RUN, STOP:
  - IDLE: count held 0, clk_out 0. A transfer loads active_div and burst immediately. en=1 -> RUN next cycle, count starts at 0. The first toggle occurs after active_div+1 RUN cycles.
  - RUN: a transfer stores into pend_div/pend_burst and sets pending=1. At a period boundary with pending=1: active_div<=pend_div, burst<=pend_burst, pending<=0. en=0 -> STOP.
  - STOP: keep counting until the next period boundary, then IDLE with clk_out=0. Pending is applied on that boundary. If en=1 again before the boundary -> RUN, with no glitch and no counter reset.
- Burst: if burst!=0, each period boundary decrements the remaining count. When it reaches 0: done=1, return to IDLE, clk_out=0.
  - A newly applied burst value restarts the remaining count.
  - Burst completion and en=0 in the same cycle: done asserts, go to IDLE.
  - Burst completion with pending=1: the pending value is applied on entering IDLE.
- Simultaneous events: a transfer in the same cycle as a period boundary goes to pending and takes effect at the following boundary.
- Reset mid-operation: immediate return to reset values. Any pending config is lost, and no done pulse is produced.
- busy = (state != IDLE).
- Widths: count and divide values are unsigned CNT_W. Compare with equality only; active_div never changes mid-period, so the counter cannot overshoot.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {IDLE, RUN, STOP}
  - CNT_W and BURST_W defaults
  - DEFAULT_DIV constant
- Sub-module div_counter: count register, terminal compare, clk_out toggle and tick. It takes active_div and a run enable, and reports terminal/boundary. The FSM, handshake, pending and burst logic stay in clk_div_ctrl.

Test Plan:
- Reset with DEFAULT_DIV=3, en=1 -> clk_out toggles every 4 cycles (period 8); tick pulses 4 cycles apart; busy=1; active_div=3.
- In IDLE, send cfg_div=1, cfg_burst=2, then en=1 -> exactly 2 periods of length 4, done pulses once, return to IDLE with clk_out=0, busy=0.
- RUN with div=3, send cfg_div=0 mid high phase -> cfg_ready drops to 0; current period completes at length 8; next period has length 2; cfg_ready returns to 1; active_div=0.
- RUN, drop en mid low phase -> counting continues to the boundary, then IDLE. A second case re-raises en before the boundary -> stays RUN, with no extra or short pulse.
- Transfer coinciding with a period boundary -> the new div applies one period later, not immediately.
- Assert rst during a burst with pending=1 -> all outputs take reset values next cycle; no done; active_div=DEFAULT_DIV.

Source files
------------

// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared types and default constants for the run-time
//               divided-clock controller.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Default width of the half-period counter and of the divide value
    localparam int          c_CNT_W       = 32;
    // Default width of the burst period count
    localparam int          c_BURST_W     = 16;
    // Divide value loaded at reset; half-period = DIV+1 clk cycles
    localparam int unsigned c_DEFAULT_DIV = 32'd25_000_000;

    // Controller operating state
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/div_counter.sv
`default_nettype none
// ============================================================================
// Module      : div_counter
// Description : Half-period counter for the divided clock. Counts while
//               i_run is high, toggles the output clock on the terminal
//               count and reports the period boundary (falling toggle).
// Revision    : 1.0 - initial release
// ============================================================================
module div_counter
    import clk_div_pkg::*;
#(
    parameter int CNT_W = c_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_run,
    input  logic [CNT_W-1:0] i_div,
    output logic             o_clk_out,
    output logic             o_tick,
    output logic             o_boundary
);

    logic [CNT_W-1:0] r_count;
    logic             r_clk_out;
    logic             r_tick;
    logic             w_terminal;

    // Equality is enough: the divide value only changes on a boundary,
    // where the count is already back at zero, so it can never overshoot.
    assign w_terminal = i_run && (r_count == i_div);

    // Count half-periods, toggle the output level and flag the toggle cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count   <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= w_terminal;
            if (i_run) begin
                if (w_terminal) begin
                    r_count   <= '0;
                    r_clk_out <= ~r_clk_out;
                end else begin
                    r_count <= r_count + CNT_W'(1);
                end
            end
        end
    end

    assign o_clk_out  = r_clk_out;
    assign o_tick     = r_tick;
    // A boundary is the terminal count that takes the output from 1 to 0
    assign o_boundary = w_terminal && r_clk_out;

endmodule
`default_nettype wire

// File: rtl/clk_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_ctrl
// Description : Run-time controller for the divided-clock generator.
//               Accepts new divide/burst settings over valid/ready, applies
//               them only on full-period boundaries, and supports run/stop
//               and N-period burst operation.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int          CNT_W       = c_CNT_W,
    parameter int unsigned DEFAULT_DIV = c_DEFAULT_DIV,
    parameter int          BURST_W     = c_BURST_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_div,
    input  logic [BURST_W-1:0] cfg_burst,
    output logic               clk_out,
    output logic               tick,
    output logic               done,
    output logic               busy,
    output logic [CNT_W-1:0]   active_div
);

    localparam logic [CNT_W-1:0]   c_RESET_DIV = CNT_W'(DEFAULT_DIV);
    localparam logic [BURST_W-1:0] c_BURST_ONE = BURST_W'(1);

    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_active_div;
    logic [BURST_W-1:0] r_burst;
    logic               r_pending;
    logic [CNT_W-1:0]   r_pend_div;
    logic [BURST_W-1:0] r_pend_burst;
    logic               r_done;

    logic               w_run;
    logic               w_xfer;
    logic               w_boundary;
    logic               w_burst_done;

    assign w_run        = (r_state != IDLE);
    assign cfg_ready    = (r_state == IDLE) || !r_pending;
    assign w_xfer       = cfg_valid && cfg_ready;
    // Last period of a finite burst ends on this boundary
    assign w_burst_done = w_boundary && (r_burst == c_BURST_ONE);

    div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk        (clk),
        .rst        (rst),
        .i_run      (w_run),
        .i_div      (r_active_div),
        .o_clk_out  (clk_out),
        .o_tick     (tick),
        .o_boundary (w_boundary)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: stopping and burst completion only leave on a boundary
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (en) begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (w_burst_done) begin
                    w_next_state = IDLE;
                end else if (!en) begin
                    w_next_state = STOP;
                end
            end
            STOP: begin
                if (w_burst_done) begin
                    w_next_state = IDLE;
                end else if (en) begin
                    w_next_state = RUN;
                end else if (w_boundary) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Configuration handling: immediate load in IDLE, deferred to the next
    // boundary while running; burst countdown on each boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            r_active_div <= c_RESET_DIV;
            r_burst      <= '0;
            r_pending    <= 1'b0;
            r_pend_div   <= '0;
            r_pend_burst <= '0;
            r_done       <= 1'b0;
        end else begin
            r_done <= w_burst_done;
            if (r_state == IDLE) begin
                // A setting captured on the very boundary that ended a run
                // is still pending here; apply it now unless a new one wins.
                if (w_xfer) begin
                    r_active_div <= cfg_div;
                    r_burst      <= cfg_burst;
                end else if (r_pending) begin
                    r_active_div <= r_pend_div;
                    r_burst      <= r_pend_burst;
                end
                r_pending <= 1'b0;
            end else begin
                if (w_boundary) begin
                    if (r_pending) begin
                        r_active_div <= r_pend_div;
                        r_burst      <= r_pend_burst;
                        r_pending    <= 1'b0;
                    end else if (r_burst != '0) begin
                        r_burst <= r_burst - c_BURST_ONE;
                    end
                end
                // Only possible while nothing is pending, so this never
                // overwrites a setting that is still waiting for a boundary
                if (w_xfer) begin
                    r_pend_div   <= cfg_div;
                    r_pend_burst <= cfg_burst;
                    r_pending    <= 1'b1;
                end
            end
        end
    end

    assign done       = r_done;
    assign busy       = w_run;
    assign active_div = r_active_div;

endmodule
`default_nettype wire
